// File: rtl/gbe_tx_arbiter.sv
// gbe_tx_arbiter: round-robin owner of the GbE TX packet buffer write port.
// Tracks committed-but-undrained packets and bytes so the buffer never overruns.
//
// Ports:
//   mac_clk, reset             clock, synchronous active-high reset
//   req/grant                  per-producer level request, registered one-hot grant
//   req_txd/addr/len/we/done   flattened per-producer write bundles
//   packet_txd/addr/len/we/done  muxed write bundle to the packet buffer
//   mac_txdv                   buffer MAC-side valid; its falling edge = one packet sent
//   pkts_inflight, bytes_inflight, busy   status
module gbe_tx_arbiter #(
    parameter int N_REQ     = 3,
    parameter int MAX_PKTS  = 7,
    parameter int BUF_BYTES = 4096,
    parameter int MAX_LEN   = 2047
) (
    input  logic                 mac_clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     grant,
    input  logic [8*N_REQ-1:0]   req_txd,
    input  logic [11*N_REQ-1:0]  req_addr,
    input  logic [11*N_REQ-1:0]  req_len,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [N_REQ-1:0]     req_done,
    output logic [7:0]           packet_txd,
    output logic [10:0]          packet_addr,
    output logic [10:0]          packet_len,
    output logic                 packet_we,
    output logic                 packet_done,
    input  logic                 mac_txdv,
    output logic [3:0]           pkts_inflight,
    output logic [12:0]          bytes_inflight,
    output logic                 busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]         state;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_next;
    logic [IW-1:0]      pick;
    logic               pick_found;
    logic [N_REQ-1:0]   pick_oh;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IW:0]        sum;
    logic [10:0]        len_q;
    logic [10:0]        sel_len;
    logic               sel_done;
    logic               eligible;
    logic               commit;
    logic               drain;
    logic               txdv_q;
    logic [10:0]        fifo_mem [8];
    logic [2:0]         wp;
    logic [2:0]         rp;
    logic [3:0]         fcnt;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
    assign req_dbl = {req, req};

    always_comb begin
        req_rot    = N_REQ'(req_dbl >> rr_ptr);
        pick_found = 1'b0;
        pick       = '0;
        sum        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, rr_ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N_REQ)) begin
                    sum = sum - (IW+1)'(N_REQ);
                end
                pick       = sum[IW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_oh[i] = (pick == IW'(i));
        end
    end

    assign rr_next = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);

    // Grant is one-hot, so an OR-mux over the held grant selects the owner.
    always_comb begin
        packet_txd  = '0;
        packet_addr = '0;
        sel_len     = '0;
        packet_we   = 1'b0;
        sel_done    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                packet_txd  = req_txd[8*i +: 8];
                packet_addr = req_addr[11*i +: 11];
                sel_len     = req_len[11*i +: 11];
                packet_we   = req_we[i];
                sel_done    = req_done[i];
            end
        end
    end

    // Length is frozen while done is up so the buffer sees a stable value.
    assign packet_len  = (state == ST_DONE) ? len_q : sel_len;
    assign packet_done = sel_done;
    assign busy        = |grant;

    assign eligible = (pkts_inflight < 4'(MAX_PKTS)) &&
                      (bytes_inflight <= 13'(BUF_BYTES - MAX_LEN));
    assign commit   = (state == ST_DONE) && !sel_done;
    // A drain edge with nothing recorded is spurious and dropped.
    assign drain    = txdv_q && !mac_txdv && (fcnt != 4'd0);

    always_ff @(posedge mac_clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            len_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (eligible && pick_found) begin
                        grant <= pick_oh;
                        gidx  <= pick;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (sel_done) begin
                        len_q <= sel_len;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!sel_done) begin
                        grant  <= '0;
                        rr_ptr <= rr_next;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mac_clk) begin
        if (reset) begin
            txdv_q         <= 1'b0;
            wp             <= '0;
            rp             <= '0;
            fcnt           <= '0;
            pkts_inflight  <= '0;
            bytes_inflight <= '0;
            for (int i = 0; i < 8; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            txdv_q <= mac_txdv;
            if (commit) begin
                fifo_mem[wp] <= len_q;
                wp           <= wp + 3'd1;
            end
            if (drain) begin
                rp <= rp + 3'd1;
            end
            fcnt <= fcnt + {3'b0, commit} - {3'b0, drain};
            pkts_inflight <= pkts_inflight + {3'b0, commit}
                             - {3'b0, drain};
            bytes_inflight <= bytes_inflight
                              + (commit ? {2'b0, len_q} : 13'd0)
                              - (drain ? {2'b0, fifo_mem[rp]} : 13'd0);
        end
    end

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// tb_gbe_tx_arbiter: directed bench for gbe_tx_arbiter.
// Expected counters come from a queue of in-flight packet lengths.
module tb_gbe_tx_arbiter;
    logic        mac_clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  grant;
    logic [23:0] req_txd = '0;
    logic [32:0] req_addr = '0;
    logic [32:0] req_len = '0;
    logic [2:0]  req_we = '0;
    logic [2:0]  req_done = '0;
    logic [7:0]  packet_txd;
    logic [10:0] packet_addr;
    logic [10:0] packet_len;
    logic        packet_we;
    logic        packet_done;
    logic        mac_txdv = 1'b0;
    logic [3:0]  pkts_inflight;
    logic [12:0] bytes_inflight;
    logic        busy;

    int total = 0;
    int bad = 0;
    int wecnt = 0;
    bit run = 1'b0;
    int q[$];

    gbe_tx_arbiter dut (
        .mac_clk(mac_clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .req_txd(req_txd),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_we(req_we),
        .req_done(req_done),
        .packet_txd(packet_txd),
        .packet_addr(packet_addr),
        .packet_len(packet_len),
        .packet_we(packet_we),
        .packet_done(packet_done),
        .mac_txdv(mac_txdv),
        .pkts_inflight(pkts_inflight),
        .bytes_inflight(bytes_inflight),
        .busy(busy)
    );

    always #5 mac_clk = ~mac_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    task automatic cycle_check();
        int s;
        int g;
        if (run) begin
            s = 0;
            foreach (q[i]) s += q[i];
            chk("pkts", int'(pkts_inflight), q.size());
            chk("bytes", int'(bytes_inflight), s);
            chk("busy", int'(busy), int'(grant != 0));
            chk("onehot", int'($onehot0(grant)), 1);
            g = -1;
            for (int i = 0; i < 3; i++) if (grant[i]) g = i;
            if (g < 0) begin
                chk("idle_we", int'(packet_we), 0);
                chk("idle_done", int'(packet_done), 0);
                chk("idle_txd", int'(packet_txd), 0);
                chk("idle_addr", int'(packet_addr), 0);
                chk("idle_len", int'(packet_len), 0);
            end else begin
                chk("mux_we", int'(packet_we), int'(req_we[g]));
                chk("mux_txd", int'(packet_txd),
                    int'(req_txd[8*g +: 8]));
                chk("mux_addr", int'(packet_addr),
                    int'(req_addr[11*g +: 11]));
                chk("mux_done", int'(packet_done), int'(req_done[g]));
                if (!req_done[g])
                    chk("mux_len", int'(packet_len),
                        int'(req_len[11*g +: 11]));
            end
            if (packet_we) wecnt++;
        end
    endtask

    task automatic step();
        @(negedge mac_clk);
        cycle_check();
        @(posedge mac_clk);
        #1;
    endtask

    task automatic wait_grant(output int who, output int lat);
        who = -1;
        lat = 0;
        while (grant == 0 && lat < 40) begin
            step();
            lat++;
        end
        chk("grant_seen", int'(grant != 0), 1);
        for (int i = 0; i < 3; i++) if (grant[i]) who = i;
    endtask

    task automatic send_pkt(input int p, input int len,
                            input bit drain_with);
        req_len[11*p +: 11] = 11'(len);
        for (int b = 0; b < len; b++) begin
            req_we[p] = 1'b1;
            req_addr[11*p +: 11] = 11'(b);
            req_txd[8*p +: 8] = 8'(b * 7 + p);
            step();
        end
        req_we[p] = 1'b0;
        req_done[p] = 1'b1;
        if (drain_with) mac_txdv = 1'b1;
        step();
        req_len[11*p +: 11] = 11'h5a5;
        step();
        chk("done_len", int'(packet_len), len);
        chk("done_flag", int'(packet_done), 1);
        req_len[11*p +: 11] = 11'(len);
        req_done[p] = 1'b0;
        if (drain_with) mac_txdv = 1'b0;
        step();
        if (drain_with && q.size() > 0) void'(q.pop_front());
        q.push_back(len);
        chk("release_grant", int'(grant), 0);
    endtask

    task automatic drain();
        mac_txdv = 1'b1;
        step();
        step();
        mac_txdv = 1'b0;
        step();
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic grab_send(input int p, input int len);
        int who;
        int lat;
        req[p] = 1'b1;
        wait_grant(who, lat);
        req[p] = 1'b0;
        chk("grab_who", who, p);
        if (who >= 0) send_pkt(who, len, 1'b0);
    endtask

    initial begin
        int who;
        int lat;
        int order[4];

        reset = 1'b1;
        step();
        step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(packet_we), 0);
        chk("rst_done", int'(packet_done), 0);
        chk("rst_len", int'(packet_len), 0);
        chk("rst_pkts", int'(pkts_inflight), 0);
        chk("rst_bytes", int'(bytes_inflight), 0);
        reset = 1'b0;
        run = 1'b1;

        // round robin from a fresh pointer
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_grant(who, lat);
            order[n] = who;
            if (who >= 0) send_pkt(who, 16, 1'b0);
        end
        req = 3'b000;
        chk("rr_0", order[0], 0);
        chk("rr_1", order[1], 1);
        chk("rr_2", order[2], 2);
        chk("rr_3", order[3], 0);
        chk("rr_bytes", int'(bytes_inflight), 64);
        repeat (4) drain();

        // single producer, 64 bytes
        step();
        wecnt = 0;
        req[0] = 1'b1;
        wait_grant(who, lat);
        chk("t1_who", who, 0);
        chk("t1_lat", lat, 1);
        req[0] = 1'b0;
        if (who >= 0) send_pkt(who, 64, 1'b0);
        chk("t1_we_pulses", wecnt, 64);
        chk("t1_pkts", int'(pkts_inflight), 1);
        chk("t1_bytes", int'(bytes_inflight), 64);
        drain();
        chk("t1_pkts_drained", int'(pkts_inflight), 0);
        chk("t1_bytes_drained", int'(bytes_inflight), 0);

        // packet-count limit
        repeat (7) grab_send(1, 32);
        chk("t3_pkts", int'(pkts_inflight), 7);
        req[2] = 1'b1;
        repeat (6) step();
        chk("t3_blocked", int'(grant), 0);
        drain();
        wait_grant(who, lat);
        chk("t3_who", who, 2);
        chk("t3_lat", int'(lat <= 2), 1);
        req[2] = 1'b0;
        if (who >= 0) send_pkt(who, 32, 1'b0);
        repeat (7) drain();

        // byte limit
        grab_send(0, 1100);
        grab_send(0, 1100);
        chk("t4_bytes", int'(bytes_inflight), 2200);
        req[0] = 1'b1;
        repeat (6) step();
        chk("t4_blocked", int'(grant), 0);
        drain();
        wait_grant(who, lat);
        chk("t4_who", who, 0);
        chk("t4_lat", int'(lat <= 2), 1);
        req[0] = 1'b0;
        if (who >= 0) send_pkt(who, 8, 1'b0);
        chk("t4_bytes2", int'(bytes_inflight), 1108);
        drain();
        drain();

        // simultaneous commit and drain
        grab_send(2, 40);
        chk("t5_pkts0", int'(pkts_inflight), 1);
        chk("t5_bytes0", int'(bytes_inflight), 40);
        req[1] = 1'b1;
        wait_grant(who, lat);
        req[1] = 1'b0;
        if (who >= 0) send_pkt(who, 100, 1'b1);
        chk("t5_pkts", int'(pkts_inflight), 1);
        chk("t5_bytes", int'(bytes_inflight), 100);

        // reset mid-packet
        req[1] = 1'b1;
        wait_grant(who, lat);
        req[1] = 1'b0;
        req_len[11 +: 11] = 11'd200;
        req_we[1] = 1'b1;
        repeat (10) step();
        reset = 1'b1;
        step();
        q.delete();
        chk("t6_grant", int'(grant), 0);
        chk("t6_we", int'(packet_we), 0);
        chk("t6_pkts", int'(pkts_inflight), 0);
        chk("t6_bytes", int'(bytes_inflight), 0);
        reset = 1'b0;
        req_we = '0;
        drain();
        chk("t6_spur_pkts", int'(pkts_inflight), 0);
        chk("t6_spur_bytes", int'(bytes_inflight), 0);
        wecnt = 0;
        for (int n = 0; n < 6; n++) begin
            req_we = (n % 2 == 1) ? 3'b101 : 3'b000;
            step();
        end
        req_we = '0;
        chk("t6_no_we", wecnt, 0);
        grab_send(1, 20);
        chk("t6_restart_bytes", int'(bytes_inflight), 20);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
